systolic_feeder: RTL

Operand transmitter for the DIM x DIM systolic multiply array built from PE_UNIT tiles. It accepts one k-slice per beat: column k of A and row k of B. It emits these as diagonally skewed, zero-padded streams onto the array's left and top edges, so that A[i][k] and B[k][j] meet in PE[i][j] on the same cycle. It also sequences the array: it clears the accumulators before a job and flags when every res_o is final.

---
 rtl/systolic_feeder_pkg.sv | 14 +
 rtl/systolic_feeder_if.sv | 38 +++
 rtl/systolic_feeder_skew_delay_line.sv | 24 ++
 rtl/systolic_feeder.sv | 103 ++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// systolic_pkg: shared FSM states and sizing helpers for systolic_feeder
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, FLUSH} state_e;
  localparam int DIM_DEF = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int FLUSH_CYCLES = 2 * DIM_DEF - 1;
  localparam int CNT_W = $clog2(2 * DIM_DEF + 1);
  function automatic int flush_cycles(int dim);
    return 2 * dim - 1;
  endfunction
  function automatic int cnt_w(int dim);
    return $clog2(2 * dim + 1);
  endfunction
endpackage

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: source/feeder/array bundle; FEEDER_OVF_EN adds carry_i and ovf_o
interface systolic_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM = 4
);
  import systolic_pkg::*;
  logic start_i;
  logic valid_i;
  logic ready_o;
  logic pe_rst_no;
  logic busy_o;
  logic done_o;
  logic [DIM*DATA_WIDTH-1:0] a_col_i;
  logic [DIM*DATA_WIDTH-1:0] b_row_i;
  logic [DIM*DATA_WIDTH-1:0] left_o;
  logic [DIM*DATA_WIDTH-1:0] up_o;
`ifdef FEEDER_OVF_EN
  logic [DIM*DIM-1:0] carry_i;
  logic ovf_o;
  modport master (
    output start_i, valid_i, a_col_i, b_row_i, carry_i,
    input ready_o, left_o, up_o, pe_rst_no, busy_o, done_o, ovf_o
  );
  modport slave (
    input start_i, valid_i, a_col_i, b_row_i, carry_i,
    output ready_o, left_o, up_o, pe_rst_no, busy_o, done_o, ovf_o
  );
`else
  modport master (
    output start_i, valid_i, a_col_i, b_row_i,
    input ready_o, left_o, up_o, pe_rst_no, busy_o, done_o
  );
  modport slave (
    input start_i, valid_i, a_col_i, b_row_i,
    output ready_o, left_o, up_o, pe_rst_no, busy_o, done_o
  );
`endif
endinterface

// File: rtl/systolic_feeder_skew_delay_line.sv
// skew_delay_line: zero-filled DEPTH-stage shift register with sync clear and shift enable
module skew_delay_line
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] sr_q;
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      sr_q <= '0;
    end else if (en_i) begin
      sr_q[0] <= d_i;
      for (int n = 1; n < DEPTH; n++) sr_q[n] <= sr_q[n-1];
    end
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: skews A/B k-slices onto systolic array edges, sequences clear/done; FEEDER_OVF_EN adds sticky ovf_o
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DIM = DIM_DEF
) (
  input logic clk_i,
  input logic rst_i,
  systolic_feeder_if.slave bus
);
  localparam int CW = cnt_w(DIM);
  localparam int FC = flush_cycles(DIM);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ready_q, busy_q, done_q, pe_rst_nq;
  logic [DIM*DATA_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH-1:0] left_w [DIM];
  logic [DATA_WIDTH-1:0] up_w [DIM];
  logic acc, shift, clr, last_beat, flush_end;
  assign acc = bus.valid_i && ready_q;
  assign shift = state_q == LOAD || state_q == FLUSH;
  assign clr = rst_i || !shift;
  assign last_beat = cnt_q == CW'(DIM - 1);
  assign flush_end = state_q == FLUSH && cnt_q == CW'(FC);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: state_d = bus.start_i ? CLEAR : IDLE;
      CLEAR: begin
        state_d = LOAD;
        cnt_d = '0;
      end
      LOAD: begin
        state_d = acc && last_beat ? FLUSH : LOAD;
        cnt_d = !acc ? cnt_q : last_beat ? '0 : cnt_q + CW'(1);
      end
      FLUSH: begin
        state_d = flush_end ? IDLE : FLUSH;
        cnt_d = flush_end ? '0 : cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pe_rst_nq <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= state_d == LOAD;
      busy_q <= state_d != IDLE;
      done_q <= flush_end;
      pe_rst_nq <= state_d != CLEAR;
      a_q <= acc ? bus.a_col_i : '0;
      b_q <= acc ? bus.b_row_i : '0;
    end
  end
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    skew_delay_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_a (
      .clk_i(clk_i),
      .clr_i(clr),
      .en_i (shift),
      .d_i  (a_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .q_o  (left_w[i])
    );
    skew_delay_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_b (
      .clk_i(clk_i),
      .clr_i(clr),
      .en_i (shift),
      .d_i  (b_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .q_o  (up_w[i])
    );
  end
  always_comb begin
    bus.left_o = '0;
    bus.up_o = '0;
    for (int n = 0; n < DIM; n++) begin
      bus.left_o[n*DATA_WIDTH +: DATA_WIDTH] = left_w[n];
      bus.up_o[n*DATA_WIDTH +: DATA_WIDTH] = up_w[n];
    end
  end
  assign bus.ready_o = ready_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.pe_rst_no = pe_rst_nq;
`ifdef FEEDER_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || state_d == CLEAR) ovf_q <= 1'b0;
    else if (shift) ovf_q <= ovf_q | (|bus.carry_i);
  end
  assign bus.ovf_o = ovf_q;
`endif
endmodule
